// File: rtl/irs_block_readout_sequencer.sv
// Readout sequencer: queues triggered IRS block addresses and walks each through lock, digitize, free.
// Optional macro IRS_READOUT_DROP_COUNT_EN adds a saturating dropped-trigger counter output.
module irs_block_readout_sequencer #(
    parameter int FIFO_DEPTH_LOG2 = 3,
    parameter int ACK_TIMEOUT     = 255
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       enable_i,
    input  logic       trig_strobe_i,
    input  logic [8:0] trig_block_i,
    output logic       trig_full_o,
    output logic [8:0] lock_address_o,
    output logic       lock_o,
    output logic       lock_strobe_o,
    input  logic       lock_ack_i,
    output logic       dig_req_o,
    output logic [8:0] dig_block_o,
    input  logic       dig_done_i,
    output logic [8:0] free_address_o,
    output logic       free_strobe_o,
    input  logic       free_ack_i,
    output logic       dead_o,
    input  logic       dead_clear_i,
    output logic       err_timeout_o
`ifdef IRS_READOUT_DROP_COUNT_EN
    ,
    output logic [15:0] drop_count_o
`endif
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOCK, S_DIG, S_FREE} state_t;

    state_t                     state_q, state_d;
    logic [8:0]                 fifo_mem_q [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
    logic [7:0]                 tmo_q, tmo_d;
    logic [8:0]                 cur_q, cur_d;
    logic [8:0]                 lock_addr_q, lock_addr_d;
    logic [8:0]                 dig_block_q, dig_block_d;
    logic [8:0]                 free_addr_q, free_addr_d;
    logic                       lock_strobe_q, lock_strobe_d;
    logic                       dig_req_q, dig_req_d;
    logic                       free_strobe_q, free_strobe_d;
    logic                       dead_q, dead_d;
    logic                       err_q, err_d;
    logic                       pop, push, drop, tmo_hit, full;
    logic [8:0]                 head;

    // Occupancy is a power of two deep, so the count MSB is set exactly when full.
    assign full = count_q[FIFO_DEPTH_LOG2];
    assign head = fifo_mem_q[rd_ptr_q];

`ifdef IRS_READOUT_DROP_COUNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop)              drop_cnt_d = dead_clear_i ? 16'd1 : sat_inc16(drop_cnt_q);
        else if (dead_clear_i) drop_cnt_d = 16'd0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) drop_cnt_q <= 16'd0;
        else          drop_cnt_q <= drop_cnt_d;
    end

    assign drop_count_o = drop_cnt_q;
`endif

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        tmo_d       = tmo_q;
        lock_addr_d = lock_addr_q;
        dig_block_d = dig_block_q;
        free_addr_d = free_addr_q;
        pop         = 1'b0;
        tmo_hit     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable_i && (count_q != '0)) begin
                    pop         = 1'b1;
                    cur_d       = head;
                    lock_addr_d = head;
                    tmo_d       = 8'd0;
                    state_d     = S_LOCK;
                end
            end
            S_LOCK: begin
                tmo_d = tmo_q + 8'd1;
                if (lock_ack_i) begin
                    dig_block_d = cur_q;
                    state_d     = S_DIG;
                end else if (tmo_q == TMO_LAST) begin
                    // Lock never granted: still free the block so the manager stays consistent.
                    tmo_hit     = 1'b1;
                    tmo_d       = 8'd0;
                    free_addr_d = cur_q;
                    state_d     = S_FREE;
                end
            end
            S_DIG: begin
                if (dig_done_i) begin
                    tmo_d       = 8'd0;
                    free_addr_d = cur_q;
                    state_d     = S_FREE;
                end
            end
            default: begin
                tmo_d = tmo_q + 8'd1;
                if (free_ack_i) begin
                    state_d = S_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_hit = 1'b1;
                    state_d = S_IDLE;
                end
            end
        endcase

        // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
        push     = trig_strobe_i && (!full || pop);
        drop     = trig_strobe_i && full && !pop;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        lock_strobe_d = (state_d == S_LOCK);
        dig_req_d     = (state_d == S_DIG);
        free_strobe_d = (state_d == S_FREE);
        dead_d        = drop    ? 1'b1 : (dead_clear_i ? 1'b0 : dead_q);
        err_d         = tmo_hit ? 1'b1 : (dead_clear_i ? 1'b0 : err_q);
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem_q[wr_ptr_q] <= trig_block_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            tmo_q         <= 8'd0;
            cur_q         <= 9'd0;
            lock_addr_q   <= 9'd0;
            dig_block_q   <= 9'd0;
            free_addr_q   <= 9'd0;
            lock_strobe_q <= 1'b0;
            dig_req_q     <= 1'b0;
            free_strobe_q <= 1'b0;
            dead_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            tmo_q         <= tmo_d;
            cur_q         <= cur_d;
            lock_addr_q   <= lock_addr_d;
            dig_block_q   <= dig_block_d;
            free_addr_q   <= free_addr_d;
            lock_strobe_q <= lock_strobe_d;
            dig_req_q     <= dig_req_d;
            free_strobe_q <= free_strobe_d;
            dead_q        <= dead_d;
            err_q         <= err_d;
        end
    end

    assign trig_full_o    = full;
    assign lock_address_o = lock_addr_q;
    assign lock_strobe_o  = lock_strobe_q;
    assign lock_o         = lock_strobe_q;
    assign dig_req_o      = dig_req_q;
    assign dig_block_o    = dig_block_q;
    assign free_address_o = free_addr_q;
    assign free_strobe_o  = free_strobe_q;
    assign dead_o         = dead_q;
    assign err_timeout_o  = err_q;

endmodule
